// File: rtl/switch_io_ctrl.sv
// rtl/switch_io_ctrl.sv - synchronised, debounced DIP switch read peripheral; optional interrupt under SWITCH_IRQ_EN
module switch_io_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SwitchCtrl,
  input  logic                ioRead,
  input  logic [1:0]          addr_in,
  input  logic [SW_WIDTH-1:0] sw_in,
`ifdef SWITCH_IRQ_EN
  input  logic                irq_mask,
  output logic                sw_irq,
`endif
  output logic [15:0]         io_rdata
);

  // Last count value before a persistent mismatch is accepted into stable.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] OFF_STABLE = 2'b00;
  localparam logic [1:0] OFF_FLAG   = 2'b10;

  logic [SW_WIDTH-1:0]            sync1;
  logic [SW_WIDTH-1:0]            sync2;
  logic [SW_WIDTH-1:0]            stable;
  logic [SW_WIDTH-1:0]            stable_nxt;
  logic [SW_WIDTH-1:0]            upd;
  logic [SW_WIDTH-1:0][CNT_W-1:0] cnt;
  logic [SW_WIDTH-1:0][CNT_W-1:0] cnt_nxt;
  logic                           change_flag;
  logic                           rd_en;
  logic                           flag_clr;

  assign rd_en    = SwitchCtrl & ioRead;
  assign flag_clr = rd_en & (addr_in == OFF_FLAG);

  // Two-flop synchroniser for the asynchronous board switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: count consecutive mismatches, accept on the last count, clear on agreement.
  always_comb begin
    stable_nxt = stable;
    upd        = '0;
    cnt_nxt    = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
          upd[i]        = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state: accepted switch levels and their mismatch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      cnt    <= '0;
    end else begin
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Sticky change flag; a stable update on the same edge as a clearing read keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_flag <= 1'b0;
    end else if (|upd) begin
      change_flag <= 1'b1;
    end else if (flag_clr) begin
      change_flag <= 1'b0;
    end
  end

  // Combinational read mux so data is valid in the same cycle as the single-cycle CPU's read.
  always_comb begin
    io_rdata = 16'h0000;
    if (rd_en) begin
      case (addr_in)
        OFF_STABLE: io_rdata = 16'(stable);
        OFF_FLAG:   io_rdata = {15'b0, change_flag};
        default:    io_rdata = 16'h0000;
      endcase
    end
  end

`ifdef SWITCH_IRQ_EN
  assign sw_irq = change_flag & ~irq_mask;
`endif

endmodule

// File: tb/tb_switch_io_ctrl.sv
// tb/tb_switch_io_ctrl.sv - self-checking bench for switch_io_ctrl with a behavioural debounce model
module tb_switch_io_ctrl;

  localparam int D = 4;

  logic        clk;
  logic        rst_n;
  logic        SwitchCtrl;
  logic        ioRead;
  logic [1:0]  addr_in;
  logic [15:0] sw_in;
  logic [15:0] io_rdata;
`ifdef SWITCH_IRQ_EN
  logic        irq_mask;
  logic        sw_irq;
`endif

  int errors;
  int checks;

  switch_io_ctrl #(
    .SW_WIDTH(16),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SwitchCtrl(SwitchCtrl),
    .ioRead(ioRead),
    .addr_in(addr_in),
    .sw_in(sw_in),
`ifdef SWITCH_IRQ_EN
    .irq_mask(irq_mask),
    .sw_irq(sw_irq),
`endif
    .io_rdata(io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the switch value seen by the debouncer lags sw_in by two edges; a bit
  // takes the opposite level once that lagged value has disagreed with the
  // accepted level on D consecutive edges.
  logic [15:0] m_d1;
  logic [15:0] m_d2;
  logic [15:0] m_win [0:D-2];
  int          m_nval;
  logic [15:0] m_stable;
  logic        m_flag;
  logic [15:0] m_upd;

  always_comb begin
    m_upd = '0;
    for (int b = 0; b < 16; b++) begin
      logic ad;
      ad = (m_nval >= D - 1) && (m_d2[b] != m_stable[b]);
      for (int j = 0; j < D - 1; j++) begin
        if (m_win[j][b] == m_stable[b]) ad = 1'b0;
      end
      m_upd[b] = ad;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1     <= '0;
      m_d2     <= '0;
      m_nval   <= 0;
      m_stable <= '0;
      m_flag   <= 1'b0;
      for (int j = 0; j < D - 1; j++) m_win[j] <= '0;
    end else begin
      m_d1     <= sw_in;
      m_d2     <= m_d1;
      m_win[0] <= m_d2;
      for (int j = 1; j < D - 1; j++) m_win[j] <= m_win[j-1];
      m_nval   <= (m_nval < D) ? m_nval + 1 : D;
      m_stable <= m_stable ^ m_upd;
      if (|m_upd) m_flag <= 1'b1;
      else if (SwitchCtrl && ioRead && addr_in == 2'b10) m_flag <= 1'b0;
    end
  end

  function automatic logic [15:0] exp_rdata();
    if (!(SwitchCtrl && ioRead)) return 16'h0000;
    case (addr_in)
      2'b00:   return m_stable;
      2'b10:   return {15'b0, m_flag};
      default: return 16'h0000;
    endcase
  endfunction

  // Continuous comparison against the model on the inactive clock edge.
  always @(negedge clk) begin
    logic [15:0] e;
    e = exp_rdata();
    checks++;
    if (io_rdata !== e) begin
      errors++;
      $display("FAIL cmp_rdata t=%0t got %h expected %h", $time, io_rdata, e);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    sw_in      = 16'hFFFF;
    SwitchCtrl = 1'b1;
    ioRead     = 1'b1;
    addr_in    = 2'b00;
`ifdef SWITCH_IRQ_EN
    irq_mask   = 1'b0;
`endif

    // Reset and first acceptance of all-ones
    tick(3);
    chk("reset_rdata", io_rdata, 16'h0000);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("post_reset_edge%0d", i), io_rdata, 16'h0000);
    end
    tick(1);
    chk("post_reset_edge6", io_rdata, 16'hFFFF);

    // Flag set by that update, cleared by a read of offset 2
    addr_in = 2'b10;
    #1;
    chk("flag_after_reset", io_rdata, 16'h0001);
    tick(1);
    chk("flag_cleared", io_rdata, 16'h0000);
    addr_in = 2'b00;

    // Return to all-zeros and clear the flag
    sw_in = 16'h0000;
    tick(6);
    chk("back_to_zero", io_rdata, 16'h0000);
    addr_in = 2'b10;
    tick(1);
    addr_in = 2'b00;

    // Debounce latency
    sw_in = 16'h00A5;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("latency_pre%0d", i), io_rdata, 16'h0000);
    end
    tick(1);
    chk("latency_post", io_rdata, 16'h00A5);
    addr_in = 2'b10;
    #1;
    chk("latency_flag", io_rdata, 16'h0001);
    tick(1);
    chk("latency_flag_clr", io_rdata, 16'h0000);
    addr_in = 2'b00;

    // Glitch on bit 3 for three cycles
    sw_in = 16'h00AD;
    tick(3);
    sw_in = 16'h00A5;
    tick(8);
    chk("glitch_stable", io_rdata, 16'h00A5);
    addr_in = 2'b10;
    #1;
    chk("glitch_flag", io_rdata, 16'h0000);
    addr_in = 2'b00;

    // Clear on the same edge as a stable update: set wins
    sw_in = 16'h00A4;
    tick(5);
    addr_in = 2'b10;
    #1;
    chk("collide_before", io_rdata, 16'h0000);
    tick(1);
    chk("collide_set_wins", io_rdata, 16'h0001);
    tick(1);
    chk("collide_then_clr", io_rdata, 16'h0000);
    addr_in = 2'b00;

    // Read gating and unused offsets
    sw_in = 16'h1234;
    tick(7);
    chk("gate_stable", io_rdata, 16'h1234);
    SwitchCtrl = 1'b0;
    #1;
    chk("gate_no_cs", io_rdata, 16'h0000);
    SwitchCtrl = 1'b1;
    ioRead     = 1'b0;
    #1;
    chk("gate_no_rd", io_rdata, 16'h0000);
    ioRead  = 1'b1;
    addr_in = 2'b01;
    #1;
    chk("offset1", io_rdata, 16'h0000);
    addr_in = 2'b11;
    #1;
    chk("offset3", io_rdata, 16'h0000);
    addr_in = 2'b00;
    #1;
    chk("offset0_again", io_rdata, 16'h1234);

    // Asynchronous reset between edges with counters at 2
    sw_in = 16'hFFFF;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stable", io_rdata, 16'h0000);
    addr_in = 2'b10;
    #1;
    chk("async_rst_flag", io_rdata, 16'h0000);
    addr_in = 2'b00;
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("rearm_edge%0d", i), io_rdata, 16'h0000);
    end
    tick(1);
    chk("rearm_edge6", io_rdata, 16'hFFFF);

`ifdef SWITCH_IRQ_EN
    chk("irq_unmasked", {15'b0, sw_irq}, 16'h0001);
    irq_mask = 1'b1;
    #1;
    chk("irq_masked", {15'b0, sw_irq}, 16'h0000);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
